// File: rtl/gold_support_ctrl_if.sv
// rtl/gold_support_ctrl_if.sv - pixel, bag and result signals of the gold support controller
interface gold_support_ctrl_if;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [10:0] goldTLX_a;
    logic [10:0] goldTLY_a;
    logic [10:0] goldTLX_b;
    logic [10:0] goldTLY_b;
    logic        dirt_dr;
    logic        digger_dr;
    logic        gold_dr;
    logic [3:0]  gold_state;
    logic        can_fall_a;
    logic        can_fall_b;
    logic        collision;
    logic        been_eaten;
    logic        gold_eaten_pulse;

    modport master (
        output startOfFrame, pixelX, pixelY, goldTLX_a, goldTLY_a, goldTLX_b, goldTLY_b,
               dirt_dr, digger_dr, gold_dr, gold_state,
        input  can_fall_a, can_fall_b, collision, been_eaten, gold_eaten_pulse
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY, goldTLX_a, goldTLY_a, goldTLX_b, goldTLY_b,
               dirt_dr, digger_dr, gold_dr, gold_state,
        output can_fall_a, can_fall_b, collision, been_eaten, gold_eaten_pulse
    );
endinterface

// File: rtl/gold_support_ctrl.sv
// rtl/gold_support_ctrl.sv - per-bag tunnel sensing, release FSMs and eat scoring for two gold bags
module gold_support_ctrl #(
    parameter logic [8:0] SUPPORT_THRESHOLD = 9'd192,
    parameter int         STRIP_H           = 8
) (
    input  logic               clk,
    input  logic               reset,
    gold_support_ctrl_if.slave bus
);
    typedef enum logic [1:0] {HELD = 2'd0, DOUBT = 2'd1, FREE = 2'd2} state_t;

    localparam logic [11:0] STRIP_H12 = 12'(STRIP_H);

    logic [11:0]       px, py;
    logic [1:0][11:0]  tlx, tly;
    logic [1:0]        in_rect, strip, hit, unsup;
    logic [1:0][8:0]   cnt_q, cnt_d;
    state_t            state_q [2];
    state_t            state_d [2];
    logic [1:0]        can_fall_q, can_fall_d;
    logic [1:0]        eaten_q, eaten_d, set_eat;
    logic              pulse_q, pulse_d;
    logic              collision, been_eaten;

    // Bounds widened to 12 bits so bags near the screen edge never wrap.
    assign px  = {1'b0, bus.pixelX};
    assign py  = {1'b0, bus.pixelY};
    assign tlx = {{1'b0, bus.goldTLX_b}, {1'b0, bus.goldTLX_a}};
    assign tly = {{1'b0, bus.goldTLY_b}, {1'b0, bus.goldTLY_a}};

    always_comb begin
        in_rect = '0;
        strip   = '0;
        hit     = '0;
        unsup   = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < 2; i++) begin
            in_rect[i] = (px >= tlx[i]) && (px <= tlx[i] + 12'd31) &&
                         (py >= tly[i]) && (py <= tly[i] + 12'd31);
            strip[i]   = (px >= tlx[i]) && (px <= tlx[i] + 12'd31) &&
                         (py >= tly[i] + 12'd32) && (py <= tly[i] + 12'd31 + STRIP_H12);
            hit[i]     = strip[i] && !bus.dirt_dr;
            unsup[i]   = cnt_q[i] >= SUPPORT_THRESHOLD;
            if (bus.startOfFrame)
                cnt_d[i] = {8'd0, hit[i]};
            else if (hit[i] && cnt_q[i] != 9'd256)
                cnt_d[i] = cnt_q[i] + 9'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            if (bus.startOfFrame) begin
                case (state_q[i])
                    HELD:    state_d[i] = unsup[i] ? DOUBT : HELD;
                    DOUBT:   state_d[i] = unsup[i] ? FREE  : HELD;
                    FREE:    state_d[i] = unsup[i] ? FREE  : HELD;
                    default: state_d[i] = HELD;
                endcase
            end
        end
    end

    // Release level is registered from the next state so it rises on the entering edge.
    always_comb begin
        can_fall_d = '0;
        for (int i = 0; i < 2; i++)
            can_fall_d[i] = (state_d[i] == FREE);
    end

    assign collision  = bus.digger_dr && bus.gold_dr;
    assign been_eaten = collision && (bus.gold_state == 4'd2);

    always_comb begin
        set_eat    = '0;
        set_eat[0] = been_eaten && in_rect[0] && !eaten_q[0];
        set_eat[1] = been_eaten && !in_rect[0] && in_rect[1] && !eaten_q[1];
        eaten_d    = eaten_q | set_eat;
        pulse_d    = |set_eat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            state_q[0] <= HELD;
            state_q[1] <= HELD;
            can_fall_q <= '0;
            eaten_q    <= '0;
            pulse_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            can_fall_q <= can_fall_d;
            eaten_q    <= eaten_d;
            pulse_q    <= pulse_d;
        end
    end

    assign bus.can_fall_a       = can_fall_q[0];
    assign bus.can_fall_b       = can_fall_q[1];
    assign bus.collision        = collision;
    assign bus.been_eaten       = been_eaten;
    assign bus.gold_eaten_pulse = pulse_q;
endmodule

// File: tb/tb_gold_support_ctrl.sv
// tb/tb_gold_support_ctrl.sv - directed bench with a frame-level model of bag support and scoring
module tb_gold_support_ctrl;
    localparam int TH = 192;
    localparam int SH = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    gold_support_ctrl_if bus();

    gold_support_ctrl #(.SUPPORT_THRESHOLD(9'd192), .STRIP_H(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Model: tunnel count per bag and how many consecutive unsupported frames were seen (capped at 2).
    int m_cnt [2];
    int m_lvl [2];
    bit m_eaten [2];
    bit m_pulse;
    bit cmp_en = 1'b0;
    int tlx [2];
    int tly [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_strip(input int i, input int x, input int y);
        return x >= tlx[i] && x <= tlx[i] + 31 && y >= tly[i] + 32 && y < tly[i] + 32 + SH;
    endfunction

    function automatic bit in_rect(input int i, input int x, input int y);
        return x >= tlx[i] && x <= tlx[i] + 31 && y >= tly[i] && y <= tly[i] + 31;
    endfunction

    task automatic set_bags(input int ax, input int ay, input int bx, input int by);
        tlx[0] = ax; tly[0] = ay; tlx[1] = bx; tly[1] = by;
        bus.goldTLX_a = 11'(ax); bus.goldTLY_a = 11'(ay);
        bus.goldTLX_b = 11'(bx); bus.goldTLY_b = 11'(by);
    endtask

    task automatic idle_inputs();
        bus.startOfFrame = 1'b0;
        bus.pixelX = 11'd0;
        bus.pixelY = 11'd0;
        bus.dirt_dr = 1'b1;
        bus.digger_dr = 1'b0;
        bus.gold_dr = 1'b0;
        bus.gold_state = 4'd0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_lvl[i] = 0; m_eaten[i] = 1'b0;
        end
        m_pulse = 1'b0;
    endtask

    task automatic step(input int x, input int y, input bit dirt, input bit sof,
                        input bit dig, input bit gdr, input int gst);
        bit hitv;
        bit be;
        @(negedge clk);
        bus.pixelX = 11'(x); bus.pixelY = 11'(y);
        bus.dirt_dr = dirt; bus.startOfFrame = sof;
        bus.digger_dr = dig; bus.gold_dr = gdr; bus.gold_state = 4'(gst);
        #1;
        chk("collision", {31'd0, bus.collision}, {31'd0, dig && gdr});
        chk("been_eaten", {31'd0, bus.been_eaten}, {31'd0, dig && gdr && gst == 2});
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            hitv = in_strip(i, x, y) && !dirt;
            if (sof) begin
                if (m_cnt[i] >= TH) m_lvl[i] = (m_lvl[i] == 2) ? 2 : m_lvl[i] + 1;
                else m_lvl[i] = 0;
                m_cnt[i] = hitv ? 1 : 0;
            end else if (hitv && m_cnt[i] < 256) begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
        be = dig && gdr && gst == 2;
        m_pulse = 1'b0;
        if (be) begin
            if (in_rect(0, x, y)) begin
                if (!m_eaten[0]) begin m_eaten[0] = 1'b1; m_pulse = 1'b1; end
            end else if (in_rect(1, x, y)) begin
                if (!m_eaten[1]) begin m_eaten[1] = 1'b1; m_pulse = 1'b1; end
            end
        end
        #2;
    endtask

    task automatic idle_step();
        step(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // n tunnel pixels (raster order) in bag i's strip, the rest dirt, then a startOfFrame pixel.
    task automatic frame(input int i, input int n, input int sx, input int sy, input bit sdirt);
        for (int yy = 0; yy < SH; yy++)
            for (int xx = 0; xx < 32; xx++)
                step((tlx[i] + xx) % 2048, (tly[i] + 32 + yy) % 2048,
                     (yy * 32 + xx) >= n, 1'b0, 1'b0, 1'b0, 0);
        step(sx, sy, sdirt, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        model_clear();
        #1;
        bus.digger_dr = 1'b1; bus.gold_dr = 1'b1; bus.gold_state = 4'd2;
        #1;
        chk("rst_collision", {31'd0, bus.collision}, 32'd1);
        chk("rst_been_eaten", {31'd0, bus.been_eaten}, 32'd1);
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        #1;
        if (cmp_en) begin
            chk("can_fall_a", {31'd0, bus.can_fall_a}, {31'd0, m_lvl[0] == 2});
            chk("can_fall_b", {31'd0, bus.can_fall_b}, {31'd0, m_lvl[1] == 2});
            chk("gold_eaten_pulse", {31'd0, bus.gold_eaten_pulse}, {31'd0, m_pulse});
        end
    end

    initial begin
        idle_inputs();
        set_bags(192, 192, 200, 193);
        model_clear();
        do_reset();
        chk("reset_cf_a", {31'd0, bus.can_fall_a}, 32'd0);
        chk("reset_cf_b", {31'd0, bus.can_fall_b}, 32'd0);
        chk("reset_pulse", {31'd0, bus.gold_eaten_pulse}, 32'd0);
        cmp_en = 1'b1;

        frame(0, 256, 0, 0, 1'b1);
        chk("full_f1_cf_a", {31'd0, bus.can_fall_a}, 32'd0);
        frame(0, 256, 0, 0, 1'b1);
        chk("full_f2_cf_a", {31'd0, bus.can_fall_a}, 32'd1);
        chk("full_f2_cf_b", {31'd0, bus.can_fall_b}, 32'd0);
        frame(0, 0, 0, 0, 1'b1);
        chk("free_to_held", {31'd0, bus.can_fall_a}, 32'd0);

        do_reset();
        frame(0, 191, 0, 0, 1'b1);
        frame(0, 191, 0, 0, 1'b1);
        chk("n191_cf_a", {31'd0, bus.can_fall_a}, 32'd0);
        do_reset();
        frame(0, 192, 0, 0, 1'b1);
        chk("n192_f1_cf_a", {31'd0, bus.can_fall_a}, 32'd0);
        frame(0, 192, 0, 0, 1'b1);
        chk("n192_f2_cf_a", {31'd0, bus.can_fall_a}, 32'd1);

        do_reset();
        frame(0, 191, 192, 224, 1'b0);
        frame(0, 191, 0, 0, 1'b1);
        frame(0, 256, 0, 0, 1'b1);
        chk("sof_pixel_counted", {31'd0, bus.can_fall_a}, 32'd1);

        do_reset();
        frame(0, 256, 0, 0, 1'b1);
        for (int k = 0; k < 150; k++) step(192 + k % 32, 224 + k / 32, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        do_reset();
        step(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        chk("midreset_sof_cf_a", {31'd0, bus.can_fall_a}, 32'd0);
        frame(0, 256, 0, 0, 1'b1);
        chk("midreset_f1_cf_a", {31'd0, bus.can_fall_a}, 32'd0);
        frame(0, 256, 0, 0, 1'b1);
        chk("midreset_f2_cf_a", {31'd0, bus.can_fall_a}, 32'd1);

        do_reset();
        set_bags(192, 192, 100, 2040);
        frame(1, 256, 0, 0, 1'b1);
        frame(1, 256, 0, 0, 1'b1);
        chk("edge_no_wrap_cf_b", {31'd0, bus.can_fall_b}, 32'd0);

        do_reset();
        set_bags(192, 192, 200, 200);
        step(200, 200, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        chk("rest_overlap_no_pulse", {31'd0, bus.gold_eaten_pulse}, 32'd0);
        step(200, 200, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        chk("eat_a_pulse", {31'd0, bus.gold_eaten_pulse}, 32'd1);
        idle_step();
        chk("eat_a_pulse_one_cycle", {31'd0, bus.gold_eaten_pulse}, 32'd0);
        step(201, 200, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        chk("repeat_eat_no_pulse", {31'd0, bus.gold_eaten_pulse}, 32'd0);
        step(210, 210, 1'b1, 1'b0, 1'b1, 1'b1, 5);
        step(230, 230, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        chk("eat_b_pulse", {31'd0, bus.gold_eaten_pulse}, 32'd1);
        idle_step();

        do_reset();
        step(210, 210, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        chk("both_rect_a_pulse", {31'd0, bus.gold_eaten_pulse}, 32'd1);
        step(230, 230, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        chk("later_b_pulse", {31'd0, bus.gold_eaten_pulse}, 32'd1);
        step(215, 215, 1'b1, 1'b0, 1'b1, 1'b1, 2);
        chk("both_eaten_no_pulse", {31'd0, bus.gold_eaten_pulse}, 32'd0);
        step(0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        idle_step();

        cmp_en = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
